// File: rtl/chess_tick_timer.sv
// ---------------------------------------------------------------------------
// chess_tick_timer
//   Per-player two-digit BCD countdown core for the chess clock. The value
//   (00..99) decrements once every p_divider clocks while i_run is high.
//   It supports a Fischer-style bonus on i_add, and flags zero and low time.
//
//   Ports
//     i_clk    system clock
//     i_rst    asynchronous, active-low reset
//     i_load   one-cycle pulse: load i_init (digits > 9 clamp to 9),
//              clear prescaler
//     i_init   BCD load value, [0] = units, [1] = tens
//     i_run    level: count down while high
//     i_add    one-cycle pulse: add p_bonus seconds (ignored at 00)
//     o_digit  current BCD value, [0] = units, [1] = tens
//     o_tick   one-cycle pulse after each applied decrement
//     o_zero   value == 00
//     o_low    0 < value <= p_low
// ---------------------------------------------------------------------------
module chess_tick_timer #(
   parameter int p_divider = 50_000_000,
   parameter int p_bonus   = 2,
   parameter int p_low     = 10
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_load,
   input  logic [1:0][3:0] i_init,
   input  logic            i_run,
   input  logic            i_add,
   output logic [1:0][3:0] o_digit,
   output logic            o_tick,
   output logic            o_zero,
   output logic            o_low
);

   localparam int              lp_pw        = (p_divider > 2) ? $clog2(p_divider) : 1;
   localparam logic [lp_pw-1:0] lp_presc_max = lp_pw'(p_divider - 1);
   localparam logic [3:0]      lp_bonus_u   = 4'(p_bonus % 10);
   localparam logic [3:0]      lp_bonus_t   = 4'(p_bonus / 10);
   localparam logic [3:0]      lp_low_u     = 4'(p_low % 10);
   localparam logic [3:0]      lp_low_t     = 4'(p_low / 10);

   logic [lp_pw-1:0] r_presc;
   logic [1:0][3:0]  r_digit;
   logic             r_tick;
   logic             r_zero;
   logic             r_low;

   logic             w_dec;
   logic             w_add;
   logic [4:0]       w_sum_u;
   logic [4:0]       w_sum_t;
   logic             w_carry;
   logic             w_sat;
   logic [3:0]       w_add_u;
   logic [3:0]       w_add_t;
   logic [3:0]       w_next_u;
   logic [3:0]       w_next_t;
   logic             w_next_zero;
   logic             w_next_low;
   logic [lp_pw-1:0] w_next_presc;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // A decrement event fires on the last prescaler count of a running,
   // non-zero period; a coincident load discards it.
   assign w_dec = i_run & ~r_zero & ~i_load & (r_presc == lp_presc_max);
   // A flagged player stays flagged: bonus is ignored at 00.
   assign w_add = i_add & ~r_zero & ~i_load;

   // NOTE: every signal written here gets a value on every path before any
   // conditional logic, so no latch is inferred.
   always_comb begin
      w_sum_u  = 5'd0;
      w_sum_t  = 5'd0;
      w_carry  = 1'b0;
      w_sat    = 1'b0;
      w_add_u  = r_digit[0];
      w_add_t  = r_digit[1];
      w_next_u = r_digit[0];
      w_next_t = r_digit[1];

      // BCD add stage: bonus (or zero) added digit-wise with decimal carry.
      w_sum_u = {1'b0, r_digit[0]} + (w_add ? {1'b0, lp_bonus_u} : 5'd0);
      w_carry = (w_sum_u > 5'd9);
      w_add_u = w_carry ? (w_sum_u[3:0] - 4'd10) : w_sum_u[3:0];
      w_sum_t = {1'b0, r_digit[1]} + (w_add ? {1'b0, lp_bonus_t} : 5'd0)
                + {4'd0, w_carry};
      w_sat   = (w_sum_t > 5'd9);
      w_add_t = w_sum_t[3:0];

      // BCD subtract stage. An overflowed sum is >= 100, so even after the
      // decrement it is >= 99: saturate before subtracting, not after.
      if (i_load) begin
         w_next_u = clamp_bcd(i_init[0]);
         w_next_t = clamp_bcd(i_init[1]);
      end else if (w_sat) begin
         w_next_u = 4'd9;
         w_next_t = 4'd9;
      end else if (w_dec) begin
         if (w_add_u != 4'd0) begin
            w_next_u = w_add_u - 4'd1;
            w_next_t = w_add_t;
         end else if (w_add_t != 4'd0) begin
            w_next_u = 4'd9;
            w_next_t = w_add_t - 4'd1;
         end else begin
            w_next_u = 4'd0;
            w_next_t = 4'd0;
         end
      end else begin
         w_next_u = w_add_u;
         w_next_t = w_add_t;
      end
   end

   assign w_next_zero = (w_next_u == 4'd0) && (w_next_t == 4'd0);
   assign w_next_low  = ~w_next_zero &&
                        ((w_next_t < lp_low_t) ||
                         ((w_next_t == lp_low_t) && (w_next_u <= lp_low_u)));

   // Prescaler holds while paused so the fractional second survives a pause;
   // it is parked at 0 whenever the value is (or becomes) 00.
   always_comb begin
      w_next_presc = r_presc;
      if (i_load || r_zero || w_next_zero) begin
         w_next_presc = '0;
      end else if (i_run) begin
         w_next_presc = (r_presc == lp_presc_max) ? '0 : (r_presc + lp_pw'(1));
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_presc <= '0;
         r_digit <= '0;
         r_tick  <= 1'b0;
         r_zero  <= 1'b1;
         r_low   <= 1'b0;
      end else begin
         r_presc    <= w_next_presc;
         r_digit[0] <= w_next_u;
         r_digit[1] <= w_next_t;
         r_tick     <= w_dec;
         r_zero     <= w_next_zero;
         r_low      <= w_next_low;
      end
   end

   assign o_digit = r_digit;
   assign o_tick  = r_tick;
   assign o_zero  = r_zero;
   assign o_low   = r_low;

endmodule

// File: doc/chess_tick_timer.md
Name: chess_tick_timer

Overview:
Per-player BCD countdown core for the chess clock. It holds a two-digit seconds value (00..99) and decrements it once per p_divider clocks while enabled. It supports a Fischer-style bonus increment and flags zero and low-time conditions. The player interface instantiates it and feeds its digits into the segment encoders; the game FSM consumes o_zero and o_low.

Parameters:
p_divider, 50_000_000, clocks per one-second decrement; must be >= 2.
p_bonus, 2, seconds added on each i_add pulse; range 0..99.
p_low, 10, o_low asserts while value <= p_low and value != 0.

Ports:
i_clk  input  1  system clock
i_rst  input  1  reset, asynchronous, active-low
i_load  input  1  one-cycle pulse; load value from i_init, clear prescaler
i_init  input  [3:0] x [1:0]  BCD init value; [0] = units, [1] = tens
i_run  input  1  level; count down while high
i_add  input  1  one-cycle pulse; add p_bonus seconds
o_digit  output  [3:0] x [1:0]  current BCD value; [0] = units, [1] = tens
o_tick  output  1  one-cycle pulse on each decrement
o_zero  output  1  value == 00
o_low  output  1  0 < value <= p_low

Behaviour:
- Reset (i_rst = 0, async):
  - o_digit = 00, prescaler = 0, o_tick = 0, o_zero = 1, o_low = 0.
  - Reset mid-count abandons the count immediately.
- All outputs are registered. Effects of a load, add or decrement are visible on the cycle after the causing edge.
- Prescaler:
  - Counts 0..p_divider-1 when i_run = 1, o_zero = 0 and i_load = 0.
  - Holds its count when i_run = 0, so a pause keeps the fractional second.
  - On reaching p_divider-1 it wraps to 0 and issues a decrement event for that cycle.
  - Cleared by i_load, and when value reaches 00.
- Priority per cycle: i_load > (i_add and/or decrement).
  - i_load: digits = i_init, with any digit > 9 clamped to 9. Prescaler = 0. Any coincident i_add or decrement is discarded.
  - Decrement only:
    - Units 1..9: units - 1.
    - Units 0, tens > 0: units = 9, tens - 1.
    - Value never goes below 00.
  - i_add only: value = min(value + p_bonus, 99), with BCD carry from units into tens.
  - i_add and decrement in the same cycle: value = min(value + p_bonus - 1, 99).
  - i_add while o_zero = 1 is ignored; a flagged player stays flagged until i_load.
- o_tick pulses high for exactly one cycle after each applied decrement. It does not pulse when the decrement is discarded by i_load, or while o_zero = 1.
- Reaching 00:
  - o_zero = 1 in the same cycle the digits read 00.
  - The prescaler stops and is cleared; i_run is then ignored.
- o_low and o_zero are derived from the registered value and settle in the same cycle as o_digit.
- Digits always hold valid BCD (0..9).
- The arithmetic uses a combinational BCD adder/subtractor on the two nibbles; no binary-to-BCD conversion.

Test Plan:
- p_divider = 4. Reset, load 12, i_run = 1 for 20 cycles -> o_tick every 4th cycle; digits 12,11,10,09,08 (tens borrow at 10->09); o_low asserts at 10.
- p_divider = 4. Load 02, run -> digits 01 then 00. o_zero rises with 00, o_tick stops, further i_run and i_add leave 00. Load 05 -> o_zero falls next cycle.
- p_bonus = 2. Load 98, pulse i_add -> 99 (saturated). Load 38, i_add timed on the decrement cycle -> 39 (38+2-1), with o_tick pulsing.
- Pause: run 2 of 4 prescaler cycles, drop i_run for 10 cycles, resume -> next decrement lands after 2 more run cycles, not 4.
- Load with i_init = {tens = 4'hC, units = 4'hA} -> digits 99. Load asserted on a decrement cycle -> loaded value wins, no o_tick.
- Assert i_rst mid-count at value 37 -> outputs go to 00 / o_zero = 1 asynchronously. After release, no tick occurs until a load.
